// File: rtl/mazecaster_pkg.sv
// Shared mazecaster constants and types used by the frame buffer and its column writer.
package mazecaster_pkg;

    localparam int unsigned SCREEN_WIDTH  = 320;
    localparam int unsigned SCREEN_HEIGHT = 180;
    localparam int unsigned FB_DEPTH      = SCREEN_WIDTH * SCREEN_HEIGHT;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_COL,
        DRAW
    } writer_state_t;

endpackage

// File: rtl/ray_column_writer_if.sv
// Column descriptor handshake from the ray caster plus the pixel write bus
// into the back frame buffer.
interface ray_column_writer_if;
    import mazecaster_pkg::*;

    logic       column_valid_in;
    logic       column_ready_out;
    logic [7:0] column_height_in;
    rgb565_t    column_color_in;
    logic       frame_start_in;

    logic [15:0] ray_address_out;
    rgb565_t     ray_pixel_out;
    logic        ray_valid_out;
    logic        ray_last_pixel_out;
    logic        busy_out;

    modport master (
        input  column_valid_in, column_height_in, column_color_in, frame_start_in,
        output column_ready_out, ray_address_out, ray_pixel_out, ray_valid_out,
        output ray_last_pixel_out, busy_out
    );

    modport slave (
        output column_valid_in, column_height_in, column_color_in, frame_start_in,
        input  column_ready_out, ray_address_out, ray_pixel_out, ray_valid_out,
        input  ray_last_pixel_out, busy_out
    );

endinterface

// File: rtl/ray_column_writer_span.sv
// Clamps a wall height to the screen and centres it vertically, giving the
// first wall row and the first floor row.
module column_span_calc #(
    parameter int unsigned SCREEN_HEIGHT = mazecaster_pkg::SCREEN_HEIGHT
) (
    input  logic [7:0] height,
    output logic [8:0] draw_start,
    output logic [8:0] draw_end
);

    localparam logic [8:0] ROWS = 9'(SCREEN_HEIGHT);

    logic [8:0] h_clamped;

    always_comb begin
        h_clamped  = ({1'b0, height} > ROWS) ? ROWS : {1'b0, height};
        draw_start = (ROWS - h_clamped) >> 1;
        draw_end   = draw_start + h_clamped;
    end

endmodule

// File: rtl/ray_column_writer.sv
// Expands per-column wall descriptors from the ray caster into RGB565 pixel
// writes for the back frame buffer, one column at a time.
module ray_column_writer #(
    parameter int unsigned SCREEN_WIDTH  = mazecaster_pkg::SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = mazecaster_pkg::SCREEN_HEIGHT,
    parameter logic [15:0] CEIL_COLOR    = 16'h0000,
    parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
    input logic                 pixel_clk_in,
    input logic                 rst_in,
    ray_column_writer_if.master bus
);
    import mazecaster_pkg::*;

    localparam logic [8:0]  X_LAST   = 9'(SCREEN_WIDTH - 1);
    localparam logic [7:0]  Y_DONE   = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]  Y_LAST   = 8'(SCREEN_HEIGHT - 1);
    localparam logic [15:0] ROW_STEP = 16'(SCREEN_WIDTH);

    writer_state_t state_q, state_d;
    logic [8:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic [15:0]   row_base_q, row_base_d;
    logic [8:0]    start_q, start_d, end_q, end_d;
    rgb565_t       wall_q, wall_d;
    logic          ready_q, busy_q;
    logic          valid_q, valid_d, last_q, last_d;
    logic [15:0]   addr_q, addr_d;
    rgb565_t       pix_q, pix_d;
    logic [8:0]    span_start, span_end;
    logic          accept;

    column_span_calc #(.SCREEN_HEIGHT(SCREEN_HEIGHT)) u_span (
        .height     (bus.column_height_in),
        .draw_start (span_start),
        .draw_end   (span_end)
    );

    function automatic rgb565_t shade(input logic [7:0] y, input logic [8:0] ds,
                                      input logic [8:0] de, input rgb565_t wall);
        logic [8:0] row;
        row = {1'b0, y};
        if (row < ds) return CEIL_COLOR;
        if (row < de) return wall;
        return FLOOR_COLOR;
    endfunction

    assign accept = (state_q == WAIT_COL) && bus.column_valid_in && ready_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        start_d    = start_q;
        end_d      = end_q;
        wall_d     = wall_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        addr_d     = addr_q;
        pix_d      = pix_q;

        case (state_q)
            IDLE: begin
                if (bus.frame_start_in) state_d = WAIT_COL;
            end
            WAIT_COL: begin
                // Row 0 is emitted straight from the span calculator on the accept
                // edge; later rows use the registered span.
                if (accept) begin
                    state_d    = DRAW;
                    start_d    = span_start;
                    end_d      = span_end;
                    wall_d     = bus.column_color_in;
                    valid_d    = 1'b1;
                    addr_d     = {7'b0, x_q};
                    pix_d      = shade(8'd0, span_start, span_end, bus.column_color_in);
                    last_d     = (x_q == X_LAST) && (Y_LAST == 8'd0);
                    y_d        = 8'd1;
                    row_base_d = {7'b0, x_q} + ROW_STEP;
                end
            end
            DRAW: begin
                if (y_q == Y_DONE) begin
                    if (x_q == X_LAST) begin
                        state_d = IDLE;
                        x_d     = '0;
                    end else begin
                        state_d = WAIT_COL;
                        x_d     = x_q + 9'd1;
                    end
                end else begin
                    valid_d    = 1'b1;
                    addr_d     = row_base_q;
                    pix_d      = shade(y_q, start_q, end_q, wall_q);
                    last_d     = (x_q == X_LAST) && (y_q == Y_LAST);
                    y_d        = y_q + 8'd1;
                    row_base_d = row_base_q + ROW_STEP;
                end
            end
            default: state_d = WAIT_COL;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q    <= WAIT_COL;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            start_q    <= '0;
            end_q      <= '0;
            wall_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            start_q    <= start_d;
            end_q      <= end_d;
            wall_q     <= wall_d;
            ready_q    <= (state_d == WAIT_COL);
            busy_q     <= (state_d != IDLE);
            valid_q    <= valid_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
        end
    end

    assign bus.column_ready_out   = ready_q;
    assign bus.busy_out           = busy_q;
    assign bus.ray_valid_out      = valid_q;
    assign bus.ray_last_pixel_out = last_q;
    assign bus.ray_address_out    = addr_q;
    assign bus.ray_pixel_out      = pix_q;

endmodule

// File: tb/tb_ray_column_writer.sv
// Randomised directed bench for ray_column_writer against a row-by-row
// reference of the expected column image.
module tb_ray_column_writer;
    import mazecaster_pkg::*;

    localparam rgb565_t     CEIL  = 16'h0000;
    localparam rgb565_t     FLOOR = 16'h4208;
    localparam int unsigned W     = SCREEN_WIDTH;
    localparam int unsigned H     = SCREEN_HEIGHT;

    typedef struct {
        logic [15:0] addr;
        rgb565_t     pix;
        logic        last;
        int unsigned cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ray_column_writer_if bus ();

    ray_column_writer #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .CEIL_COLOR    (CEIL),
        .FLOOR_COLOR   (FLOOR)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    beat_t       beats[$];
    int unsigned cyc = 0;

    // capture write beats 1 time unit after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.ray_valid_out === 1'b1)
            beats.push_back('{bus.ray_address_out, bus.ray_pixel_out, bus.ray_last_pixel_out, cyc});
    end

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned col_x  = 0;
    int unsigned frame_beats = 0;
    int unsigned last_seen   = 0;
    bit          hit[FB_DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected column image: wall centred vertically, ceiling above, floor below.
    function automatic rgb565_t ref_pixel(input int unsigned y, input int unsigned h, input rgb565_t wall);
        int unsigned hc;
        int unsigned top;
        hc  = (h > H) ? H : h;
        top = (H - hc) / 2;
        if (y < top)      return CEIL;
        if (y < top + hc) return wall;
        return FLOOR;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.ray_valid_out), 32'd0);
        check({tag, "_last"},  32'(bus.ray_last_pixel_out), 32'd0);
        check({tag, "_addr"},  32'(bus.ray_address_out), 32'd0);
        check({tag, "_pix"},   32'(bus.ray_pixel_out), 32'd0);
        check({tag, "_ready"}, 32'(bus.column_ready_out), 32'd0);
        check({tag, "_busy"},  32'(bus.busy_out), 32'd0);
    endtask

    task automatic wait_ready();
        int unsigned n;
        n = 0;
        while (bus.column_ready_out !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.column_ready_out), 32'd1);
    endtask

    task automatic run_col(input logic [7:0] h, input rgb565_t c, input int unsigned gap, input bit fs_mid);
        int unsigned e, n, x, a;
        x = col_x;
        beats.delete();
        repeat (gap) @(negedge clk);
        bus.column_valid_in  = 1'b1;
        bus.column_height_in = h;
        bus.column_color_in  = c;
        wait_ready();
        e = cyc + 1;
        @(negedge clk);
        bus.column_valid_in  = 1'b0;
        bus.column_height_in = 8'($urandom);
        bus.column_color_in  = 16'($urandom);
        check("ready_after_accept", 32'(bus.column_ready_out), 32'd0);
        if (fs_mid) begin
            repeat (20) @(negedge clk);
            bus.frame_start_in = 1'b1;
            @(negedge clk);
            bus.frame_start_in = 1'b0;
        end
        n = 0;
        while (beats.size() < H && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("beat_count",   32'(beats.size()), 32'(H));
        check("valid_bubble", 32'(bus.ray_valid_out), 32'd0);
        check("ready_next",   32'(bus.column_ready_out), (x == W - 1) ? 32'd0 : 32'd1);
        check("busy_next",    32'(bus.busy_out), (x == W - 1) ? 32'd0 : 32'd1);
        check("addr_hold",    32'(bus.ray_address_out), 32'(x + W * (H - 1)));
        check("pix_hold",     32'(bus.ray_pixel_out), 32'(ref_pixel(H - 1, 32'(h), c)));
        foreach (beats[i]) begin
            a = x + W * 32'(i);
            check("addr",        32'(beats[i].addr), 32'(a));
            check("pixel",       32'(beats[i].pix), 32'(ref_pixel(32'(i), 32'(h), c)));
            check("valid_cycle", beats[i].cyc, e + 32'(i));
            check("last_flag",   32'(beats[i].last), (a == FB_DEPTH - 1) ? 32'd1 : 32'd0);
            if (beats[i].addr < FB_DEPTH) hit[beats[i].addr] = 1'b1;
            frame_beats++;
            if (beats[i].last === 1'b1) last_seen++;
        end
        col_x = (x == W - 1) ? 0 : x + 1;
    endtask

    initial begin
        logic [7:0]  h;
        int unsigned distinct;

        bus.column_valid_in  = 1'b0;
        bus.column_height_in = '0;
        bus.column_color_in  = '0;
        bus.frame_start_in   = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        rst = 1'b0;
        check_outputs_zero("after_reset");
        @(negedge clk);
        check("ready_rise", 32'(bus.column_ready_out), 32'd1);
        check("busy_rise",  32'(bus.busy_out), 32'd1);

        run_col(8'd60,  16'hF800, 0, 1'b0);
        run_col(8'd0,   16'hFFFF, 1, 1'b0);
        run_col(8'd200, 16'h07E0, 2, 1'b0);
        run_col(8'd61,  16'h001F, 0, 1'b0);
        run_col(8'($urandom_range(0, 255)), 16'($urandom), 3, 1'b0);

        // column 5 is abandoned by a reset part-way through its rows
        bus.column_valid_in  = 1'b1;
        bus.column_height_in = 8'd100;
        bus.column_color_in  = 16'h1234;
        wait_ready();
        @(negedge clk);
        bus.column_valid_in = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_draw_valid", 32'(bus.ray_valid_out), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_draw_reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.column_ready_out), 32'd1);
        col_x = 0;

        foreach (hit[i]) hit[i] = 1'b0;
        frame_beats = 0;
        last_seen   = 0;
        for (int k = 0; k < W; k++) begin
            case ($urandom_range(0, 5))
                0:       h = 8'd0;
                1:       h = 8'd1;
                2:       h = 8'd180;
                3:       h = 8'd181;
                4:       h = 8'd255;
                default: h = 8'($urandom_range(0, 255));
            endcase
            run_col(h, 16'($urandom), $urandom_range(0, 2), k == 100);
        end
        distinct = 0;
        foreach (hit[i]) if (hit[i]) distinct++;
        check("frame_beats",    frame_beats, 32'(FB_DEPTH));
        check("frame_distinct", distinct, 32'(FB_DEPTH));
        check("frame_last_cnt", last_seen, 32'd1);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.column_ready_out), 32'd0);
        end
        bus.frame_start_in = 1'b1;
        @(negedge clk);
        bus.frame_start_in = 1'b0;
        check("start_ready", 32'(bus.column_ready_out), 32'd1);
        check("start_busy",  32'(bus.busy_out), 32'd1);
        run_col(8'd90, 16'hABCD, 1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ray_column_writer.md
# ray_column_writer

Writer side of the double-buffered frame-buffer interface. It accepts one wall-column descriptor per screen column from the ray caster (DDA), in column order 0..SCREEN_WIDTH-1. It expands each column into SCREEN_HEIGHT RGB565 pixels (ceiling, wall, floor) and streams them as address/pixel pairs into the back frame buffer. It flags the frame's final pixel so the frame buffer can swap, then waits for a frame-start pulse before accepting the next frame.

## Interface
Parameters:
- SCREEN_WIDTH, 320, columns per frame
- SCREEN_HEIGHT, 180, rows per frame
- CEIL_COLOR, 16'h0000, RGB565 ceiling colour
- FLOOR_COLOR, 16'h4208, RGB565 floor colour

Ports (one clock; reset is synchronous and active-high):
- pixel_clk_in  input  1  sole clock
- rst_in  input  1  synchronous active-high reset
- column_valid_in  input  1  column descriptor valid
- column_ready_out  output  1  writer can accept a descriptor
- column_height_in  input  8  wall height in rows; values above SCREEN_HEIGHT are clamped
- column_color_in  input  16  RGB565 wall colour
- frame_start_in  input  1  single-cycle pulse: back buffer free, begin next frame
- ray_address_out  output  16  frame-buffer address, x + SCREEN_WIDTH*y
- ray_pixel_out  output  16  RGB565 pixel
- ray_valid_out  output  1  address/pixel valid (write enable)
- ray_last_pixel_out  output  1  high with the pixel at address SCREEN_WIDTH*SCREEN_HEIGHT-1 only
- busy_out  output  1  high in every state except IDLE

## Operation
- States:
  - IDLE: waits for the next frame.
  - WAIT_COL: column_ready_out=1.
  - DRAW: emits one pixel per cycle.
- Transitions:
  - Out of reset, go to WAIT_COL. The first frame needs no frame_start_in.
  - WAIT_COL to DRAW on column_valid_in && column_ready_out. Latch the clamped height h = min(column_height_in, SCREEN_HEIGHT) and the colour.
  - DRAW ends when row y = SCREEN_HEIGHT-1 is emitted:
    - if column x < SCREEN_WIDTH-1: increment x and go to WAIT_COL;
    - else: go to IDLE with x=0.
  - IDLE to WAIT_COL on frame_start_in.
- frame_start_in is ignored in WAIT_COL and DRAW. It is not latched.
- Span computation:
  - draw_start = (SCREEN_HEIGHT - h) >> 1, with truncating division;
  - draw_end = draw_start + h.
  - Do the arithmetic at 9 bits; no overflow is possible after the clamp.
- Pixel select:
  - y < draw_start: CEIL_COLOR;
  - draw_start ≤ y < draw_end: wall colour;
  - otherwise: FLOOR_COLOR.
  - h = 0 gives no wall rows.
- Address generation is incremental, with no multiplier:
  - the row base starts at x on column accept;
  - add SCREEN_WIDTH each row.
  - Maximum address is 57599, which fits in 16 bits.
- column_valid_in may drop between columns. The writer stalls in WAIT_COL indefinitely, with ray_valid_out=0.
- Descriptor inputs are sampled only on the accept cycle. Changes during DRAW have no effect.

## Timing
- All outputs are registered.
- Values during reset and in the cycle after it: ray_valid_out=0, ray_last_pixel_out=0, ray_address_out=0, ray_pixel_out=0, column_ready_out=0, busy_out=0.
- column_ready_out rises one cycle after reset deasserts.
- Accept at cycle t: the pixel for y=0 is valid at t+1, and y=SCREEN_HEIGHT-1 at t+SCREEN_HEIGHT. ray_valid_out is continuously high over that window.
- column_ready_out reasserts in cycle t+SCREEN_HEIGHT+1. This is a one-cycle bubble per column, so a frame takes at least SCREEN_WIDTH*(SCREEN_HEIGHT+1) cycles.
- ray_last_pixel_out is a one-cycle pulse coincident with the valid pixel at address 57599.
- IDLE is entered the cycle after that pixel. column_ready_out goes high the cycle after frame_start_in is seen in IDLE.
- When ray_valid_out=0, address and pixel hold their last values.
- Reset mid-DRAW: all outputs clear the next cycle and x returns to 0. The partial column is discarded.

## Structure
- A shared package, mazecaster_pkg, holds:
  - SCREEN_WIDTH, SCREEN_HEIGHT and FB_DEPTH (57600);
  - an rgb565_t typedef;
  - the writer state enum (IDLE, WAIT_COL, DRAW).
- The frame buffer and this writer both import these constants.
- One sub-module, column_span_calc, clamps the height and produces draw_start/draw_end. It is combinational and registered at accept in the parent.
- Counters (x 9-bit, y 8-bit, row base 16-bit) and the FSM stay in ray_column_writer.

## Test plan
- Column 0, h=60, colour 16'hF800 → rows 0–59 CEIL_COLOR, rows 60–119 F800, rows 120–179 FLOOR_COLOR; addresses 0, 320, …, 57280; valid for 180 consecutive cycles starting one cycle after accept.
- h=0 → rows 0–89 ceiling, rows 90–179 floor, no wall pixel; h=200 → clamped, all 180 rows wall colour.
- h=61 → draw_start=59, draw_end=120; row 58 ceiling, rows 59 and 119 wall, row 120 floor.
- Full 320-column frame with random valid gaps:
  - exactly 57600 valid beats, every address hit once;
  - ray_last_pixel_out only at address 57599;
  - column_ready_out stays low until frame_start_in;
  - a frame_start_in pulse during DRAW is ignored.
- Reset asserted mid-DRAW of column 5 → next cycle all outputs 0. After release, the next descriptor is written as column 0 (address 0).
